// File: rtl/antisat_pkg.sv
// Shared defaults, FSM state encodings and the frame parity helper for the
// Anti-SAT key loader.
package antisat_pkg;

  localparam int               KEY_W     = 6;
  localparam logic [KEY_W-1:0] DECOY_KEY = 6'b000000;
  localparam int               MAX_FAIL  = 3;
  localparam int               CNT_W     = 2;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD    = 3'd1;
  localparam state_t S_CHECK   = 3'd2;
  localparam state_t S_ARMED   = 3'd3;
  localparam state_t S_LOCKOUT = 3'd4;

  // Even parity over key bits plus parity bit: a good frame XORs to zero.
  function automatic logic frame_parity_ok(input logic [KEY_W:0] frame);
    return ~(^frame);
  endfunction

endpackage

// File: rtl/antisat_key_shreg.sv
// Serial-in shift register for one key frame (KEY_W key bits + parity bit),
// LSB first, with a bit counter that flags acceptance of the final bit.
module antisat_key_shreg #(
  parameter int KEY_W = antisat_pkg::KEY_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           shift_en,
  input  logic           bit_in,
  output logic [KEY_W:0] frame,
  output logic           frame_done
);

  localparam int CW = $clog2(KEY_W + 2);

  logic [CW-1:0] cnt;

  // Bits enter at the top, so after KEY_W+1 shifts the first bit sits in frame[0].
  assign frame_done = shift_en && (cnt == CW'(KEY_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      frame <= {bit_in, frame[KEY_W:1]};
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/antisat_key_loader.sv
// Key-provisioning controller for the Anti-SAT-locked c432 core: receives a
// serial key frame, checks parity, arms the key or counts toward lockout.
module antisat_key_loader #(
  parameter int               KEY_W     = antisat_pkg::KEY_W,
  parameter logic [KEY_W-1:0] DECOY_KEY = antisat_pkg::DECOY_KEY,
  parameter int               MAX_FAIL  = antisat_pkg::MAX_FAIL,
  parameter int               CNT_W     = antisat_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_bit_valid,
  output logic             key_bit_ready,
  output logic [KEY_W-1:0] key_o,
  output logic             key_armed,
  output logic             load_err,
  output logic             lockout,
  output logic [CNT_W-1:0] fail_cnt
);

  import antisat_pkg::*;

  state_t         state;
  logic [KEY_W:0] frame;
  logic           frame_done;
  logic           shift_en;
  logic           clear;

  assign key_bit_ready = (state == S_LOAD);
  // A start request wins over a bit presented in the same cycle.
  assign shift_en      = key_bit_ready && key_bit_valid && !key_start;
  assign clear         = key_start &&
                         ((state == S_IDLE) || (state == S_LOAD) || (state == S_ARMED));

  antisat_key_shreg #(
    .KEY_W(KEY_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .shift_en  (shift_en),
    .bit_in    (key_bit),
    .frame     (frame),
    .frame_done(frame_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      key_o     <= DECOY_KEY;
      key_armed <= 1'b0;
      load_err  <= 1'b0;
      lockout   <= 1'b0;
      fail_cnt  <= '0;
    end else begin
      load_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (frame_done) state <= S_CHECK;
        end
        S_CHECK: begin
          if (frame_parity_ok(frame)) begin
            state     <= S_ARMED;
            key_o     <= frame[KEY_W-1:0];
            key_armed <= 1'b1;
            fail_cnt  <= '0;
          end else begin
            load_err <= 1'b1;
            if (fail_cnt >= CNT_W'(MAX_FAIL - 1)) begin
              state    <= S_LOCKOUT;
              lockout  <= 1'b1;
              fail_cnt <= CNT_W'(MAX_FAIL);
            end else begin
              state    <= S_IDLE;
              fail_cnt <= fail_cnt + CNT_W'(1);
            end
          end
        end
        S_ARMED: begin
          // The core must never see a key while a replacement is loading.
          if (key_start) begin
            state     <= S_LOAD;
            key_armed <= 1'b0;
            key_o     <= DECOY_KEY;
          end
        end
        S_LOCKOUT: begin
          state <= S_LOCKOUT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_antisat_key_loader.sv
// Self-checking bench for antisat_key_loader: frame table, hand-written
// corner sequences and a randomized run against a frame-level model.
module tb_antisat_key_loader;

  localparam logic [5:0] DECOY = 6'b000000;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_CHECK = 2;
  localparam int M_ARMED = 3;
  localparam int M_LOCK  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_start;
  logic       key_bit;
  logic       key_bit_valid;
  logic       key_bit_ready;
  logic [5:0] key_o;
  logic       key_armed;
  logic       load_err;
  logic       lockout;
  logic [1:0] fail_cnt;

  always #5 clk = ~clk;

  antisat_key_loader dut (
    .clk          (clk),
    .rst          (rst),
    .key_start    (key_start),
    .key_bit      (key_bit),
    .key_bit_valid(key_bit_valid),
    .key_bit_ready(key_bit_ready),
    .key_o        (key_o),
    .key_armed    (key_armed),
    .load_err     (load_err),
    .lockout      (lockout),
    .fail_cnt     (fail_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Free-running event recorders; the test reads snapshots of these.
  int   cyc = 0;
  int   errs = 0;
  int   accs = 0;
  int   arm_cyc = -1;
  logic armed_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (key_bit_valid && key_bit_ready && !key_start) accs <= accs + 1;
  end

  always @(negedge clk) begin
    if (load_err === 1'b1) errs = errs + 1;
    if (key_armed === 1'b1 && armed_prev !== 1'b1) arm_cyc = cyc;
    armed_prev = key_armed;
  end

  // Frame-level reference model used during the randomized run.
  logic       chk_en = 1'b0;
  int         m_mode;
  int         m_n;
  logic [6:0] m_frame;
  logic [5:0] m_key;
  logic       m_armed;
  logic       m_err;
  logic       m_lock;
  int         m_fail;

  task automatic modelReset();
    m_mode  = M_IDLE;
    m_n     = 0;
    m_frame = '0;
    m_key   = DECOY;
    m_armed = 1'b0;
    m_err   = 1'b0;
    m_lock  = 1'b0;
    m_fail  = 0;
  endtask

  task automatic modelStep(input logic ks, input logic kv, input logic kb);
    m_err = 1'b0;
    case (m_mode)
      M_IDLE: if (ks) begin m_mode = M_LOAD; m_n = 0; end
      M_LOAD: begin
        if (ks) m_n = 0;
        else if (kv) begin
          m_frame[m_n] = kb;
          m_n++;
          if (m_n == 7) m_mode = M_CHECK;
        end
      end
      M_CHECK: begin
        if ((^m_frame) == 1'b0) begin
          m_mode  = M_ARMED;
          m_key   = m_frame[5:0];
          m_armed = 1'b1;
          m_fail  = 0;
        end else begin
          m_err  = 1'b1;
          m_fail = (m_fail + 1 > 3) ? 3 : m_fail + 1;
          if (m_fail == 3) begin m_mode = M_LOCK; m_lock = 1'b1; end
          else m_mode = M_IDLE;
        end
      end
      M_ARMED: if (ks) begin m_mode = M_LOAD; m_n = 0; m_armed = 1'b0; m_key = DECOY; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      if (rst) modelReset();
      else modelStep(key_start, key_bit_valid, key_bit);
      #1;
      checkOutput("rnd key_o", key_o, m_key);
      checkOutput("rnd key_armed", key_armed, m_armed);
      checkOutput("rnd load_err", load_err, m_err);
      checkOutput("rnd lockout", lockout, m_lock);
      checkOutput("rnd fail_cnt", fail_cnt, m_fail);
      checkOutput("rnd key_bit_ready", key_bit_ready, (m_mode == M_LOAD));
    end
  end

  int start_cyc = 0;

  // key_start pulse, optional aborted prefix + restart, then 7 frame bits
  // each followed by 'gap' idle cycles, then time for CHECK to complete.
  task automatic applyStimulus(input logic [5:0] key, input logic par,
                               input int gap, input int pre);
    logic [6:0] fr;
    fr = {par, key};
    @(negedge clk);
    key_start = 1'b1; key_bit_valid = 1'b0;
    start_cyc = cyc;
    @(negedge clk);
    key_start = 1'b0;
    for (int j = 0; j < pre; j++) begin
      key_bit_valid = 1'b1; key_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
      key_bit_valid = 1'b0;
    end
    if (pre > 0) begin
      key_start = 1'b1; key_bit_valid = 1'b1; key_bit = 1'b1;
      @(negedge clk);
      key_start = 1'b0; key_bit_valid = 1'b0;
    end
    for (int i = 0; i < 7; i++) begin
      key_bit_valid = 1'b1; key_bit = fr[i];
      @(negedge clk);
      key_bit_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] key;
    logic       par;
    int         gap;
    int         pre;
    logic [5:0] exp_key;
    logic       exp_armed;
    int         exp_fail;
    logic       exp_lock;
    int         exp_errs;
    int         exp_acc;
    int         exp_lat;
  } row_t;

  row_t rows[10];

  initial begin
    int e0, a0, lat;

    rows[0] = '{6'b101101, 1'b0, 0, 0, 6'b101101, 1'b1, 0, 1'b0, 0, 7, 9};
    rows[1] = '{6'b101101, 1'b1, 0, 0, DECOY,     1'b0, 1, 1'b0, 1, 7, -1};
    rows[2] = '{6'b101101, 1'b0, 0, 0, 6'b101101, 1'b1, 0, 1'b0, 0, 7, 9};
    rows[3] = '{6'b010011, 1'b1, 0, 3, 6'b010011, 1'b1, 0, 1'b0, 0, 10, 13};
    rows[4] = '{6'b010011, 1'b0, 0, 3, DECOY,     1'b0, 1, 1'b0, 1, 10, -1};
    rows[5] = '{6'b010011, 1'b1, 2, 0, 6'b010011, 1'b1, 0, 1'b0, 0, 7, 21};
    rows[6] = '{6'b000001, 1'b0, 0, 0, DECOY,     1'b0, 1, 1'b0, 1, 7, -1};
    rows[7] = '{6'b000001, 1'b0, 0, 0, DECOY,     1'b0, 2, 1'b0, 1, 7, -1};
    rows[8] = '{6'b111111, 1'b1, 1, 0, DECOY,     1'b0, 3, 1'b1, 1, 7, -1};
    rows[9] = '{6'b101101, 1'b0, 0, 0, DECOY,     1'b0, 3, 1'b1, 0, 0, -1};

    rst = 1'b1; key_start = 1'b0; key_bit = 1'b0; key_bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset key_o", key_o, DECOY);
    checkOutput("reset key_armed", key_armed, 0);
    checkOutput("reset load_err", load_err, 0);
    checkOutput("reset lockout", lockout, 0);
    checkOutput("reset fail_cnt", fail_cnt, 0);
    checkOutput("reset key_bit_ready", key_bit_ready, 0);
    rst = 1'b0;

    for (int r = 0; r < 10; r++) begin
      e0 = errs;
      a0 = accs;
      applyStimulus(rows[r].key, rows[r].par, rows[r].gap, rows[r].pre);
      lat = (arm_cyc > start_cyc) ? (arm_cyc - start_cyc) : -1;
      checkOutput($sformatf("row%0d key_o", r), key_o, rows[r].exp_key);
      checkOutput($sformatf("row%0d key_armed", r), key_armed, rows[r].exp_armed);
      checkOutput($sformatf("row%0d fail_cnt", r), fail_cnt, rows[r].exp_fail);
      checkOutput($sformatf("row%0d lockout", r), lockout, rows[r].exp_lock);
      checkOutput($sformatf("row%0d load_err pulses", r), errs - e0, rows[r].exp_errs);
      checkOutput($sformatf("row%0d bits accepted", r), accs - a0, rows[r].exp_acc);
      checkOutput($sformatf("row%0d arm latency", r), lat, rows[r].exp_lat);
    end

    checkOutput("lockout ready", key_bit_ready, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checkOutput("unlock lockout", lockout, 0);
    checkOutput("unlock fail_cnt", fail_cnt, 0);

    // Reload from ARMED, then an asynchronous reset in the middle of it.
    applyStimulus(6'b101101, 1'b0, 0, 0);
    checkOutput("rearm key_o", key_o, 6'b101101);
    @(negedge clk); key_start = 1'b1;
    @(negedge clk); key_start = 1'b0;
    checkOutput("reload key_armed", key_armed, 0);
    checkOutput("reload key_o", key_o, DECOY);
    checkOutput("reload ready", key_bit_ready, 1);
    key_bit_valid = 1'b1; key_bit = 1'b1;
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst key_o", key_o, DECOY);
    checkOutput("async rst key_armed", key_armed, 0);
    checkOutput("async rst ready", key_bit_ready, 0);
    checkOutput("async rst fail_cnt", fail_cnt, 0);
    checkOutput("async rst lockout", lockout, 0);
    @(negedge clk); rst = 1'b0; key_bit_valid = 1'b0;

    // Randomized run against the frame-level model.
    @(negedge clk); rst = 1'b1; chk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 299) == 0);
      key_start     = ($urandom_range(0, 15) == 0);
      key_bit_valid = 1'($urandom_range(0, 1));
      key_bit       = 1'($urandom_range(0, 1));
    end
    @(negedge clk); chk_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
